repair_search_ctrl: RTL and testbench

Sequencer for the spare-candidate signal generator in the built-in repair path. It holds the generator in reset while idle, releases it on `start` and forwards every candidate (DSSS/RLSS) to the repair-analysis checker with a valid strobe. It matches in-order checker results back to their candidates and stops on the first passing candidate or when the candidate space is exhausted. It then reports the solution and returns to idle.

---
 rtl/repair_search_ctrl_if.sv | 45 ++++
 rtl/repair_search_ctrl.sv | 162 ++++++++++++++++
 tb/tb_repair_search_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/repair_search_ctrl_if.sv
// repair_search_ctrl_if: start/status, generator and checker signals of the
// repair search sequencer. The abort line exists only when SEARCH_ABORT_EN
// is defined.
interface repair_search_ctrl_if;
    logic       start;
    logic [1:0] spare_struct_type;
    logic       gen_rst;
    logic [7:0] gen_dsss;
    logic [3:0] gen_rlss;
    logic       cand_valid;
    logic [7:0] cand_dsss;
    logic [3:0] cand_rlss;
    logic       chk_valid;
    logic       chk_pass;
    logic       busy;
    logic       done;
    logic       repair_ok;
    logic [7:0] sol_dsss;
    logic [3:0] sol_rlss;
    logic [7:0] sol_idx;
    logic [7:0] cand_cnt;
`ifdef SEARCH_ABORT_EN
    logic       abort;
`endif

    // Sequencer side
    modport master (
`ifdef SEARCH_ABORT_EN
        input  abort,
`endif
        input  start, spare_struct_type, gen_dsss, gen_rlss, chk_valid, chk_pass,
        output gen_rst, cand_valid, cand_dsss, cand_rlss, busy, done, repair_ok,
        output sol_dsss, sol_rlss, sol_idx, cand_cnt
    );

    // Environment side: requester, generator and checker
    modport slave (
`ifdef SEARCH_ABORT_EN
        output abort,
`endif
        output start, spare_struct_type, gen_dsss, gen_rlss, chk_valid, chk_pass,
        input  gen_rst, cand_valid, cand_dsss, cand_rlss, busy, done, repair_ok,
        input  sol_dsss, sol_rlss, sol_idx, cand_cnt
    );
endinterface

// File: rtl/repair_search_ctrl.sv
// repair_search_ctrl: releases the spare-candidate generator on start, issues
// one candidate per cycle to the repair-analysis checker, matches the in-order
// checker results back to their candidates and stops on the first pass or
// when the candidate space (70 or 210 entries) is exhausted.
// Optional feature macro: SEARCH_ABORT_EN (adds the abort input).
module repair_search_ctrl #(
    parameter int CHK_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    repair_search_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DRAIN, DONE} state_t;

    state_t     state;
    logic [1:0] struct_type;
    logic [7:0] limit;
    logic [7:0] res_cnt;
    logic [7:0] res_next;
    logic       found;
    logic       in_search;
    logic       res_hit;
    logic       pass_hit;
    logic       abort_hit;
    logic       issue_last;

    // Issued candidates delayed to line up with their checker verdicts
    logic [CHK_LAT-1:0][7:0] dly_dsss;
    logic [CHK_LAT-1:0][3:0] dly_rlss;
    logic [CHK_LAT-1:0][7:0] dly_idx;

    assign limit      = (struct_type == 2'b11) ? 8'd210 : 8'd70;
    assign in_search  = (state == LAUNCH) || (state == RUN) || (state == DRAIN);
    assign res_hit    = in_search && bus.chk_valid;
    assign pass_hit   = res_hit && bus.chk_pass && !found;
    assign res_next   = res_cnt + {7'd0, res_hit};
    assign issue_last = (bus.cand_cnt + 8'd1) == limit;

`ifdef SEARCH_ABORT_EN
    assign abort_hit = in_search && bus.abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Shift the registered candidate and its 0-based index down the delay line
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_dsss <= '0;
            dly_rlss <= '0;
            dly_idx  <= '0;
        end else begin
            dly_dsss[0] <= bus.cand_dsss;
            dly_rlss[0] <= bus.cand_rlss;
            dly_idx[0]  <= bus.cand_cnt - 8'd1;
            for (int i = 1; i < CHK_LAT; i++) begin
                dly_dsss[i] <= dly_dsss[i-1];
                dly_rlss[i] <= dly_rlss[i-1];
                dly_idx[i]  <= dly_idx[i-1];
            end
        end
    end

    // Search sequencer with registered outputs and result matching
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            struct_type    <= 2'b00;
            res_cnt        <= 8'd0;
            found          <= 1'b0;
            bus.gen_rst    <= 1'b1;
            bus.cand_valid <= 1'b0;
            bus.cand_dsss  <= 8'd0;
            bus.cand_rlss  <= 4'd0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.repair_ok  <= 1'b0;
            bus.sol_dsss   <= 8'd0;
            bus.sol_rlss   <= 4'd0;
            bus.sol_idx    <= 8'd0;
            bus.cand_cnt   <= 8'd0;
        end else begin
            bus.done <= 1'b0;

            // Results are only meaningful while a search is in flight
            if (res_hit)
                res_cnt <= res_next;
            if (pass_hit) begin
                bus.sol_dsss  <= dly_dsss[CHK_LAT-1];
                bus.sol_rlss  <= dly_rlss[CHK_LAT-1];
                bus.sol_idx   <= dly_idx[CHK_LAT-1];
                bus.repair_ok <= 1'b1;
                found         <= 1'b1;
            end

            case (state)
                IDLE: begin
                    bus.gen_rst    <= 1'b1;
                    bus.cand_valid <= 1'b0;
                    if (bus.start) begin
                        struct_type   <= bus.spare_struct_type;
                        bus.busy      <= 1'b1;
                        bus.cand_cnt  <= 8'd0;
                        bus.repair_ok <= 1'b0;
                        bus.sol_dsss  <= 8'd0;
                        bus.sol_rlss  <= 4'd0;
                        bus.sol_idx   <= 8'd0;
                        res_cnt       <= 8'd0;
                        found         <= 1'b0;
                        if (bus.spare_struct_type == 2'b00) begin
                            // No spare structure: nothing to search
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            bus.gen_rst <= 1'b0;
                            state       <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    // Generator needs one cycle to register its first output
                    state <= RUN;
                end
                RUN: begin
                    bus.cand_valid <= 1'b1;
                    bus.cand_dsss  <= bus.gen_dsss;
                    bus.cand_rlss  <= bus.gen_rlss;
                    bus.cand_cnt   <= bus.cand_cnt + 8'd1;
                    if (issue_last || pass_hit) begin
                        bus.gen_rst <= 1'b1;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    bus.cand_valid <= 1'b0;
                    if (res_next == bus.cand_cnt) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Abort discards any solution and ends the search immediately
            if (abort_hit) begin
                bus.gen_rst    <= 1'b1;
                bus.cand_valid <= 1'b0;
                bus.repair_ok  <= 1'b0;
                bus.sol_dsss   <= 8'd0;
                bus.sol_rlss   <= 4'd0;
                bus.sol_idx    <= 8'd0;
                bus.done       <= 1'b1;
                state          <= DONE;
            end
        end
    end
endmodule

// File: tb/tb_repair_search_ctrl.sv
// tb_repair_search_ctrl: drives searches of each spare type against a
// behavioural generator (descending 8-bit DSSS codes with four ones, RLSS
// variants per type) and a fixed-latency checker that passes chosen
// candidates; expected counts, solutions and timing come from the list.
module tb_repair_search_ctrl;
    localparam int CHK_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    repair_search_ctrl_if bus();
    repair_search_ctrl #(.CHK_LAT(CHK_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    logic [11:0] glist [0:255];
    int          glen = 0;
    int          gidx = 0;
    logic [11:0] tgt_a = 12'hFFF;
    logic [11:0] tgt_b = 12'hFFF;
    logic        inj_v = 1'b0;
    logic        inj_p = 1'b0;
    logic [CHK_LAT-1:0] vp = '0;
    logic [CHK_LAT-1:0] pp = '0;
    logic [11:0] got [$];
    int          cv_cyc [$];

    // Generator: held at its first entry by gen_rst, then one entry per cycle
    always @(posedge clk) begin
        if (bus.gen_rst) gidx <= 0;
        else begin
            if (gidx < glen) {bus.gen_dsss, bus.gen_rlss} <= glist[gidx];
            gidx <= gidx + 1;
        end
    end

    // Checker: fixed latency, passes candidates equal to a target
    always @(posedge clk) begin
        for (int i = CHK_LAT - 1; i > 0; i--) begin
            vp[i] <= vp[i-1];
            pp[i] <= pp[i-1];
        end
        vp[0] <= bus.cand_valid;
        pp[0] <= bus.cand_valid && ({bus.cand_dsss, bus.cand_rlss} == tgt_a ||
                                    {bus.cand_dsss, bus.cand_rlss} == tgt_b);
    end
    assign bus.chk_valid = vp[CHK_LAT-1] | inj_v;
    assign bus.chk_pass  = pp[CHK_LAT-1] | inj_p;

    // Candidate space of a spare type
    task automatic build_list(input logic [1:0] t);
        logic [7:0] d;
        glen = 0;
        if (t != 2'b00) begin
            for (int v = 255; v >= 0; v--) begin
                d = v[7:0];
                if ($countones(d) == 4) begin
                    if (t == 2'b11) begin
                        glist[glen] = {d, 4'b1000}; glen++;
                        glist[glen] = {d, 4'b0100}; glen++;
                        glist[glen] = {d, 4'b0010}; glen++;
                    end else begin
                        glist[glen] = {d, (t == 2'b10) ? 4'b0001 : 4'b0000}; glen++;
                    end
                end
            end
        end
    endtask

    task automatic run_search(input string nm, input logic [1:0] t, input int pa, input int pb,
                              input int repulse_at, input int abort_at);
        int n, first, exp_cnt, cyc, done_at, last_cv, first_cv, rise_at, ab_cyc, bad, exp_rise;
        logic grst_prev;
        build_list(t);
        n = glen;
        first = -1;
        if (pa >= 0 && pa < n) first = pa;
        if (pb >= 0 && pb < n && (first < 0 || pb < first)) first = pb;
        tgt_a = (pa >= 0 && pa < n) ? glist[pa] : 12'hFFF;
        tgt_b = (pb >= 0 && pb < n) ? glist[pb] : 12'hFFF;
        if (abort_at >= 0) begin first = -1; exp_cnt = abort_at + 1; end
        else if (first >= 0) exp_cnt = (first + CHK_LAT + 2 < n) ? first + CHK_LAT + 2 : n;
        else exp_cnt = n;
        got.delete(); cv_cyc.delete();
        done_at = -1; last_cv = -1; first_cv = -1; rise_at = -1; ab_cyc = -1;
        @(negedge clk);
        grst_prev = bus.gen_rst;
        bus.start = 1'b1; bus.spare_struct_type = t;
        cyc = 0;
        while (cyc < 1000 && done_at < 0) begin
            @(negedge clk); cyc++;
            bus.start = 1'b0;
`ifdef SEARCH_ABORT_EN
            bus.abort = 1'b0;
`endif
            if (bus.cand_valid) begin
                got.push_back({bus.cand_dsss, bus.cand_rlss});
                cv_cyc.push_back(cyc);
                if (first_cv < 0) first_cv = cyc;
                last_cv = cyc;
            end
            if (bus.gen_rst && !grst_prev && rise_at < 0) rise_at = cyc;
            grst_prev = bus.gen_rst;
            if (bus.done) done_at = cyc;
            if (repulse_at >= 0 && bus.cand_valid && got.size() == repulse_at) begin
                bus.start = 1'b1; bus.spare_struct_type = 2'b00;
            end
`ifdef SEARCH_ABORT_EN
            if (abort_at >= 0 && bus.cand_valid && got.size() == abort_at + 1 && ab_cyc < 0) begin
                bus.abort = 1'b1; ab_cyc = cyc;
            end
`endif
        end
        checks++;
        if (done_at < 0) begin errors++; $display("FAIL %s done_timeout: no done within 1000 cycles", nm); end
        checks++;
        if (bus.cand_cnt !== 8'(exp_cnt)) begin
            errors++; $display("FAIL %s cand_cnt: got %0d expected %0d", nm, bus.cand_cnt, exp_cnt);
        end
        checks++;
        if (got.size() != exp_cnt) begin
            errors++; $display("FAIL %s issued: got %0d expected %0d", nm, got.size(), exp_cnt);
        end
        bad = 0;
        foreach (got[i]) if (i >= n || got[i] !== glist[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL %s cand_seq: %0d wrong candidates, expected 0", nm, bad); end
        checks++;
        if (got.size() > 0 && last_cv - first_cv + 1 != got.size()) begin
            errors++; $display("FAIL %s cand_gap: span %0d expected %0d", nm, last_cv - first_cv + 1, got.size());
        end
        checks++;
        if (bus.repair_ok !== (first >= 0)) begin
            errors++; $display("FAIL %s repair_ok: got %0b expected %0b", nm, bus.repair_ok, first >= 0);
        end
        checks++;
        if (first >= 0) begin
            if ({bus.sol_dsss, bus.sol_rlss} !== glist[first] || bus.sol_idx !== 8'(first)) begin
                errors++; $display("FAIL %s solution: got %h/%h idx %0d expected %h idx %0d",
                                   nm, bus.sol_dsss, bus.sol_rlss, bus.sol_idx, glist[first], first);
            end
        end else if (bus.sol_dsss !== 8'd0 || bus.sol_rlss !== 4'd0 || bus.sol_idx !== 8'd0) begin
            errors++; $display("FAIL %s solution: got %h/%h idx %0d expected zeros",
                               nm, bus.sol_dsss, bus.sol_rlss, bus.sol_idx);
        end
        if (abort_at >= 0) begin
            checks++;
            if (done_at != ab_cyc + 1) begin
                errors++; $display("FAIL %s abort_done: at %0d expected %0d", nm, done_at, ab_cyc + 1);
            end
            checks++;
            if (bus.gen_rst !== 1'b1) begin errors++; $display("FAIL %s abort_gen_rst: got %0b expected 1", nm, bus.gen_rst); end
        end else if (t == 2'b00) begin
            checks++;
            if (done_at != 1) begin errors++; $display("FAIL %s done_time: at %0d expected 1", nm, done_at); end
        end else begin
            checks++;
            if (first_cv != 3) begin errors++; $display("FAIL %s first_cv: at %0d expected 3", nm, first_cv); end
            checks++;
            if (done_at != last_cv + CHK_LAT + 1) begin
                errors++; $display("FAIL %s done_time: at %0d expected %0d", nm, done_at, last_cv + CHK_LAT + 1);
            end
            exp_rise = last_cv;
            if (first >= 0 && first + CHK_LAT + 2 <= n)
                exp_rise = (first < cv_cyc.size()) ? cv_cyc[first] + CHK_LAT + 1 : -2;
            checks++;
            if (rise_at != exp_rise) begin
                errors++; $display("FAIL %s gen_rst_rise: at %0d expected %0d", nm, rise_at, exp_rise);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.gen_rst !== 1'b1) begin
            errors++; $display("FAIL %s back_to_idle: done=%0b busy=%0b gen_rst=%0b expected 0/0/1",
                               nm, bus.done, bus.busy, bus.gen_rst);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.gen_rst !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cand_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ctl: gen_rst=%0b busy=%0b done=%0b cv=%0b expected 1/0/0/0",
                               bus.gen_rst, bus.busy, bus.done, bus.cand_valid);
        end
        checks++;
        if ({bus.cand_dsss, bus.cand_rlss, bus.cand_cnt, bus.repair_ok} !== 21'd0 ||
            {bus.sol_dsss, bus.sol_rlss, bus.sol_idx} !== 20'd0) begin
            errors++; $display("FAIL reset_data: cand %h/%h cnt %0d ok %0b sol %h/%h idx %0d expected zeros",
                               bus.cand_dsss, bus.cand_rlss, bus.cand_cnt, bus.repair_ok,
                               bus.sol_dsss, bus.sol_rlss, bus.sol_idx);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); inj_v = ~i[0]; inj_p = 1'b1;
        end
        @(negedge clk); inj_v = 1'b0; inj_p = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.repair_ok !== 1'b0 || bus.gen_rst !== 1'b1 || bus.done !== 1'b0 ||
            {bus.sol_dsss, bus.sol_rlss, bus.sol_idx, bus.cand_cnt} !== 28'd0) begin
            errors++; $display("FAIL idle_chk_ignored: busy=%0b ok=%0b gen_rst=%0b sol_idx=%0d cnt=%0d",
                               bus.busy, bus.repair_ok, bus.gen_rst, bus.sol_idx, bus.cand_cnt);
        end
    endtask

    task automatic test_type01_nopass;
        logic [7:0] head [6] = '{8'hF0, 8'hE8, 8'hE4, 8'hE2, 8'hE1, 8'hD8};
        run_search("t01_nopass", 2'b01, -1, -1, -1, -1);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got.size() <= i || got[i] !== {head[i], 4'h0}) begin
                errors++; $display("FAIL t01_head%0d: got %h expected %h0", i, (got.size() > i) ? got[i] : 12'hXXX, head[i]);
            end
        end
        checks++;
        if (got.size() != 70 || got[69] !== 12'h0F0) begin
            errors++; $display("FAIL t01_last: size %0d expected 70 with last 0F0", got.size());
        end
    endtask

    task automatic test_type11_pass4;
        logic [11:0] head [5] = '{12'hF08, 12'hF04, 12'hF02, 12'hE88, 12'hE84};
        run_search("t11_pass4", 2'b11, 4, -1, -1, -1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got.size() <= i || got[i] !== head[i]) begin
                errors++; $display("FAIL t11_head%0d: got %h expected %h", i, (got.size() > i) ? got[i] : 12'hXXX, head[i]);
            end
        end
        checks++;
        if (bus.sol_dsss !== 8'hE8 || bus.sol_rlss !== 4'b0100 || bus.sol_idx !== 8'd4 ||
            bus.repair_ok !== 1'b1 || bus.cand_cnt !== 8'(4 + CHK_LAT + 2)) begin
            errors++; $display("FAIL t11_result: sol %h/%h idx %0d ok %0b cnt %0d expected E8/4 idx 4 ok 1 cnt %0d",
                               bus.sol_dsss, bus.sol_rlss, bus.sol_idx, bus.repair_ok, bus.cand_cnt, 4 + CHK_LAT + 2);
        end
    endtask

    task automatic test_rst_mid_run;
        build_list(2'b01); tgt_a = 12'hFFF; tgt_b = 12'hFFF;
        @(negedge clk); bus.start = 1'b1; bus.spare_struct_type = 2'b01;
        @(negedge clk); bus.start = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (bus.cand_valid !== 1'b1 || bus.gen_rst !== 1'b0) begin
            errors++; $display("FAIL mid_run_active: cv=%0b gen_rst=%0b expected 1/0", bus.cand_valid, bus.gen_rst);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.gen_rst !== 1'b1 || bus.busy !== 1'b0 || bus.cand_valid !== 1'b0 || bus.cand_cnt !== 8'd0) begin
            errors++; $display("FAIL mid_run_rst: gen_rst=%0b busy=%0b cv=%0b cnt=%0d expected 1/0/0/0",
                               bus.gen_rst, bus.busy, bus.cand_valid, bus.cand_cnt);
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.repair_ok !== 1'b0) begin
            errors++; $display("FAIL after_rst_idle: busy=%0b ok=%0b expected 0/0", bus.busy, bus.repair_ok);
        end
        run_search("restart", 2'b01, 7, -1, -1, -1);
        checks++;
        if (got.size() == 0 || got[0] !== 12'hF00) begin
            errors++; $display("FAIL restart_f0: first %h expected F00", (got.size() > 0) ? got[0] : 12'hXXX);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 6; it++) begin
            logic [1:0] t;
            int n, pa, pb;
            t  = 2'($urandom_range(1, 3));
            n  = (t == 2'b11) ? 210 : 70;
            pa = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, n - 1));
            pb = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, n - 1));
            run_search($sformatf("rand%0d", it), t, pa, pb, -1, -1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.spare_struct_type = 2'b00;
`ifdef SEARCH_ABORT_EN
        bus.abort = 1'b0;
`endif
        test_reset();
        test_type01_nopass();
        test_type11_pass4();
        run_search("t00", 2'b00, -1, -1, -1, -1);
        run_search("t10_pass", 2'b10, 20, -1, -1, -1);
        run_search("later_pass", 2'b01, 10, 11, -1, -1);
        run_search("last_and_pass", 2'b01, 70 - CHK_LAT - 2, 69, -1, -1);
        run_search("start_repulse", 2'b01, -1, -1, 5, -1);
        test_rst_mid_run();
`ifdef SEARCH_ABORT_EN
        run_search("abort10", 2'b01, -1, -1, -1, 10);
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
